hazard_unit: RTL
================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset.
REQ-002 SHALL expose the following ports, one per line, clock and reset first:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- instr_d  in  32  decode-stage instruction: rs1=[19:15], rs2=[24:20], rd=[11:7], op=[6:0]
- result_src_e  in  2  execute-stage result select; bit0=1 marks a load in E
- pc_src_e  in  1  branch taken or jump in E
- reg_write_m  in  1  M-stage register write enable
- reg_write_w  in  1  W-stage register write enable
- stall_f  out  1  hold PC
- stall_d  out  1  hold F/D register
- flush_d  out  1  clear F/D register
- flush_e  out  1  clear D/E register; drives controller flush_e
- forward_a_e  out  2  ALU operand A select: 00 regfile, 01 W result, 10 M ALU result
- forward_b_e  out  2  ALU operand B select; same encoding
- stall_cnt  out  16  count of load-use stall cycles
- flush_cnt  out  16  count of control-flush cycles

Function
REQ-003 SHALL decode source/destination usage from op:
- rs1 used unless op is 0110111, 0010111 or 1101111
- rs2 used only for op 0110011, 0100011 or 1100011
- rd written unless op is 0100011 or 1100011
- unused fields read as 5'd0
REQ-004 SHALL keep an internal shadow pipeline, updated every rising edge:
- D/E stage: rs1_e, rs2_e, rd_e, captured from the masked decode fields
- E/M stage: rd_m <- rd_e
- M/W stage: rd_w <- rd_m
REQ-005 SHALL load D/E with all zeros on an edge where flush_e=1; stall_d does not hold D/E.
REQ-006 SHALL compute forward_a_e combinationally:
- 10 if rs1_e!=0, rs1_e==rd_m and reg_write_m
- else 01 if rs1_e!=0, rs1_e==rd_w and reg_write_w
- else 00
REQ-007 SHALL compute forward_b_e identically using rs2_e; when M and W both match, M wins.
REQ-008 SHALL compute lw_stall = result_src_e[0] & rd_e!=0 & (masked rs1_d==rd_e | masked rs2_d==rd_e).
REQ-009 SHALL drive the control outputs combinationally:
- stall_f = stall_d = lw_stall & ~pc_src_e
- flush_d = pc_src_e
- flush_e = lw_stall | pc_src_e
REQ-010 SHALL give pc_src_e priority: with lw_stall and pc_src_e both 1, stalls are 0 and both flushes are 1.
REQ-011 SHALL increment stall_cnt on each edge with stall_d=1 and flush_cnt on each edge with pc_src_e=1; both saturate at 16'hFFFF and never wrap.
REQ-012 SHALL have zero latency from inputs to stall/flush/forward outputs, and one-cycle latency per shadow stage.

Reset
REQ-013 SHALL clear rs1_e, rs2_e, rd_e, rd_m, rd_w, stall_cnt and flush_cnt immediately on rst=1, without waiting for a clock edge.
REQ-014 SHALL drive, with rst held and all inputs 0: stall_f, stall_d, flush_d, flush_e = 0 and forward_a_e = forward_b_e = 00.
REQ-015 SHALL, when rst asserts mid-stall, drop stall_d on the next evaluation because rd_e=0; the first edge after rst release captures instr_d normally.

Verification
REQ-016 Load-use: instr_d=0x00002083 (lw x1,0(x0)), clock; then instr_d=0x002081B3 (add x3,x1,x2) with result_src_e=01 -> stall_f=stall_d=flush_e=1, flush_d=0; next edge rd_e=0 and stall_cnt=1; then forward_a_e=01 once rd_w=1 with reg_write_w=1.
REQ-017 M-forward: rs1_e=1, rd_m=1, reg_write_m=1, rd_w=1, reg_write_w=1 -> forward_a_e=10; drop reg_write_m -> forward_a_e=01.
REQ-018 x0 guard: instr_d=0x00000033 (add x0,x0,x0) flowing behind lw x0 -> lw_stall=0 and forward codes 00 throughout.
REQ-019 Control flush: pc_src_e=1 with result_src_e=01 and a matching rs in D -> flush_d=flush_e=1, stall_f=0; flush_cnt increments by 1 per asserted cycle.
REQ-020 Masking: instr_d=0x000010B7 (lui x1) behind load to rd_e=0 (field [19:15]=0) and behind load rd_e=2 with [24:20]=2 in the encoding -> no stall.
REQ-021 Saturation and reset: hold pc_src_e=1 for 65540 cycles -> flush_cnt=16'hFFFF; assert rst between edges -> counters read 0 immediately.

Source files
------------

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use stall, control flush, operand forwarding, event counters.
// Latency: stall/flush/forward outputs are combinational; shadow pipeline advances one stage per edge.
// Backpressure: stall_f/stall_d hold the front end on a load-use hazard; a taken branch overrides the stall.
module hazard_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_d,
    input  logic [1:0]  result_src_e,
    input  logic        pc_src_e,
    input  logic        reg_write_m,
    input  logic        reg_write_w,
    output logic        stall_f,
    output logic        stall_d,
    output logic        flush_d,
    output logic        flush_e,
    output logic [1:0]  forward_a_e,
    output logic [1:0]  forward_b_e,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    logic [6:0] op_d;
    logic       rs1_used;
    logic       rs2_used;
    logic       rd_used;
    logic [4:0] rs1_d;
    logic [4:0] rs2_d;
    logic [4:0] rd_d;

    // Shadow copies of the register specifiers travelling down the main pipeline
    logic [4:0] rs1_e;
    logic [4:0] rs2_e;
    logic [4:0] rd_e;
    logic [4:0] rd_m;
    logic [4:0] rd_w;

    logic lw_stall;

    // Instruction bits that never name a register, plus the non-load result_src encoding
    logic unused_bits;
    assign unused_bits = ^{instr_d[31:25], instr_d[14:12], result_src_e[1]};

    // Selects the bypass source for one operand; the younger M result beats W, x0 never forwards
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic [4:0] rdm, input logic wm,
                                           input logic [4:0] rdw, input logic ww);
        logic [1:0] sel;
        sel = FWD_RF;
        if (rs != 5'd0 && rs == rdm && wm)
            sel = FWD_M;
        else if (rs != 5'd0 && rs == rdw && ww)
            sel = FWD_W;
        return sel;
    endfunction

    // Decode which register fields the D-stage instruction really uses; unused fields read as x0
    always_comb begin
        op_d     = instr_d[6:0];
        rs1_used = !(op_d == OP_LUI || op_d == OP_AUIPC || op_d == OP_JAL);
        rs2_used = (op_d == OP_RTYPE || op_d == OP_STORE || op_d == OP_BRANCH);
        rd_used  = !(op_d == OP_STORE || op_d == OP_BRANCH);
        rs1_d    = rs1_used ? instr_d[19:15] : 5'd0;
        rs2_d    = rs2_used ? instr_d[24:20] : 5'd0;
        rd_d     = rd_used  ? instr_d[11:7]  : 5'd0;
    end

    // Hazard detection and control; a taken branch squashes the stall since the dependent op is discarded
    always_comb begin
        lw_stall    = result_src_e[0] && (rd_e != 5'd0) && (rs1_d == rd_e || rs2_d == rd_e);
        stall_f     = lw_stall && !pc_src_e;
        stall_d     = lw_stall && !pc_src_e;
        flush_d     = pc_src_e;
        flush_e     = lw_stall || pc_src_e;
        forward_a_e = fwd_sel(rs1_e, rd_m, reg_write_m, rd_w, reg_write_w);
        forward_b_e = fwd_sel(rs2_e, rd_m, reg_write_m, rd_w, reg_write_w);
    end

    // Advance the shadow pipeline; D/E takes a bubble on flush and is never held by stall_d
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs1_e <= 5'd0;
            rs2_e <= 5'd0;
            rd_e  <= 5'd0;
            rd_m  <= 5'd0;
            rd_w  <= 5'd0;
        end else begin
            if (flush_e) begin
                rs1_e <= 5'd0;
                rs2_e <= 5'd0;
                rd_e  <= 5'd0;
            end else begin
                rs1_e <= rs1_d;
                rs2_e <= rs2_d;
                rd_e  <= rd_d;
            end
            rd_m <= rd_e;
            rd_w <= rd_m;
        end
    end

    // Saturating event counters for load-use stall cycles and control-flush cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else begin
            if (stall_d && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
            if (pc_src_e && flush_cnt != 16'hFFFF)
                flush_cnt <= flush_cnt + 16'd1;
        end
    end

endmodule
